seg_scan_driver: RTL

- Downstream consumer stage of the display path. Multiplexes a 4-digit hex/BCD value onto a common 7-segment bus with one-hot digit enables.
- Owns its own slot prescaler, inter-digit guard (blanking) time, leading-zero suppression and tear-free frame-synchronous value update.
- Feeds the board's segment/anode pins directly.

---
 rtl/seg_scan_driver_if.sv | 23 ++
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Pin-side bundle of the 4-digit segment scan driver: load port in, display pins out.
// LOAD is a single-cycle strobe with no ready: the driver takes VALUE/DP_IN on every cycle LOAD is high.
interface seg_scan_driver_if;
    logic        LOAD;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic        LZ_EN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  DIG;
    logic        PENDING;
    logic        FRAME;

    modport master (
        output LOAD, VALUE, DP_IN, LZ_EN,
        input  SEG, DP, DIG, PENDING, FRAME
    );

    modport slave (
        input  LOAD, VALUE, DP_IN, LZ_EN,
        output SEG, DP, DIG, PENDING, FRAME
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with guard blanking, leading-zero
// suppression and frame-synchronous value update. All outputs are registered.
module seg_scan_driver #(
    parameter int DIV            = 50000,
    parameter int GUARD          = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    seg_scan_driver_if.slave bus
);
    localparam int          CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic        DP_OFF  = SEG_ACTIVE_LOW;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [19:0]   r_shadow;
    logic [19:0]   r_active;
    logic          r_pending;
    logic          r_shown;
    logic [3:0]    r_dig;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_in_guard;
    logic [3:0]    w_nib;
    logic          w_dp_lit;
    logic          w_zero_above;
    logic          w_blank;
    logic [6:0]    w_glyph;
    logic          w_dp_on;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Active-high segment pattern {g,f,e,d,c,b,a}; b and d are lowercase shapes.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    f_glyph = 7'h3F;
            4'h1:    f_glyph = 7'h06;
            4'h2:    f_glyph = 7'h5B;
            4'h3:    f_glyph = 7'h4F;
            4'h4:    f_glyph = 7'h66;
            4'h5:    f_glyph = 7'h6D;
            4'h6:    f_glyph = 7'h7D;
            4'h7:    f_glyph = 7'h07;
            4'h8:    f_glyph = 7'h7F;
            4'h9:    f_glyph = 7'h6F;
            4'hA:    f_glyph = 7'h77;
            4'hB:    f_glyph = 7'h7C;
            4'hC:    f_glyph = 7'h39;
            4'hD:    f_glyph = 7'h5E;
            4'hE:    f_glyph = 7'h79;
            default: f_glyph = 7'h71;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == CW'(DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_in_guard  = (int'(r_cnt) < GUARD);

    // Digit selection and suppression; nothing is lit until the first value lands in active.
    always_comb begin
        w_nib        = r_active[3:0];
        w_dp_lit     = r_active[16];
        w_zero_above = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nib        = r_active[3:0];
                w_dp_lit     = r_active[16];
                w_zero_above = 1'b0;
            end
            2'd1: begin
                w_nib        = r_active[7:4];
                w_dp_lit     = r_active[17];
                w_zero_above = (r_active[15:4] == 12'h000);
            end
            2'd2: begin
                w_nib        = r_active[11:8];
                w_dp_lit     = r_active[18];
                w_zero_above = (r_active[15:8] == 8'h00);
            end
            default: begin
                w_nib        = r_active[15:12];
                w_dp_lit     = r_active[19];
                w_zero_above = (r_active[15:12] == 4'h0);
            end
        endcase
        w_blank = !r_shown || (bus.LZ_EN && w_zero_above);
        w_glyph = w_blank ? 7'h00 : f_glyph(w_nib);
        w_dp_on = r_shown && w_dp_lit;
    end

    assign w_seg = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
    assign w_dp  = SEG_ACTIVE_LOW ? ~w_dp_on : w_dp_on;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_shown   <= 1'b0;
            r_dig     <= 4'b0000;
            r_seg     <= SEG_OFF;
            r_dp      <= DP_OFF;
            r_frame   <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_frame <= w_frame_end;

            if (w_in_guard) begin
                r_dig <= 4'b0000;
                r_seg <= SEG_OFF;
                r_dp  <= DP_OFF;
            end else begin
                r_dig <= 4'b0001 << r_idx;
                r_seg <= w_seg;
                r_dp  <= w_dp;
            end

            // A LOAD on the frame-end cycle stays pending: active takes the older shadow.
            if (bus.LOAD)
                r_shadow <= {bus.DP_IN, bus.VALUE};
            if (w_frame_end && r_pending) begin
                r_active <= r_shadow;
                r_shown  <= 1'b1;
            end
            if (bus.LOAD)
                r_pending <= 1'b1;
            else if (w_frame_end)
                r_pending <= 1'b0;
        end
    end

    assign bus.DIG     = r_dig;
    assign bus.SEG     = r_seg;
    assign bus.DP      = r_dp;
    assign bus.PENDING = r_pending;
    assign bus.FRAME   = r_frame;
endmodule
